instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-low; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset.
REQ-004 pc_addr  input  32  byte address presented by the program counter.
REQ-005 pc_valid  input  1  pc_addr is valid this cycle.
REQ-006 pc_ready  output  1  fetch unit accepts pc_addr this cycle; pc_valid&pc_ready is a transfer.
REQ-007 flush  input  1  discard all queued and in-flight fetches (taken branch/jump).
REQ-008 mem_req  output  1  instruction-memory read request.
REQ-009 mem_addr  output  32  word-aligned read address.
REQ-010 mem_ack  input  1  memory returns mem_rdata for the current request.
REQ-011 mem_rdata  input  32  instruction word, valid only when mem_ack=1.
REQ-012 instr_valid  output  1  instr_out/instr_pc are valid.
REQ-013 instr_ready  input  1  decode consumes the head entry; instr_valid&instr_ready is a pop.
REQ-014 instr_out  output  32  fetched instruction at queue head.
REQ-015 instr_pc  output  32  byte address of instr_out.
REQ-016 misalign_err  output  1  sticky flag: an accepted pc_addr had bits [1:0] != 0.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DRAIN; encoding is implementation choice.
REQ-018 Queue SHALL be a 2-entry FIFO of {pc[31:0], instr[31:0]}; count range 0..2; pointers wrap modulo 2.
REQ-019 pc_ready SHALL equal (state==IDLE) & (count<2) & !flush & !misalign_err.
REQ-020 Transfer of aligned address in cycle N: state->REQ, mem_req=1 and mem_addr=pc_addr from cycle N+1.
REQ-021 mem_req and mem_addr SHALL hold stable in REQ until the cycle mem_ack=1 (unbounded wait).
REQ-022 mem_ack in REQ in cycle M: push {mem_addr, mem_rdata}; state->IDLE; mem_req=0 in M+1; instr_valid=1 by M+1 when queue was empty.
REQ-023 mem_ack outside REQ/DRAIN SHALL be ignored.
REQ-024 Transfer of misaligned address: no memory request; misalign_err=1 from next cycle; state stays IDLE.
REQ-025 misalign_err SHALL clear only on flush or reset.
REQ-026 instr_valid SHALL equal (count!=0); instr_out/instr_pc show head entry, combinationally from queue.
REQ-027 Push and pop in the same cycle SHALL both occur; count unchanged; legal at count=1 and, for pop, at count=2.
REQ-028 Push SHALL never occur at count=2 (guaranteed by REQ-019, no in-flight fetch exists without space).
REQ-029 flush SHALL empty the queue (count=0, pointers 0) at the next edge; instr_valid=0 next cycle; pop that cycle ignored.
REQ-030 flush in REQ without mem_ack: state->DRAIN; mem_req/mem_addr held until mem_ack; returned data discarded; then IDLE.
REQ-031 flush in REQ with mem_ack same cycle: data discarded, state->IDLE.
REQ-032 flush in DRAIN: remain DRAIN; flush in IDLE: remain IDLE.
REQ-033 pc_ready SHALL be 0 in DRAIN; no new address accepted until DRAIN exits.
REQ-034 At most one memory request outstanding at any time.

Reset
REQ-035 reset=0 at a rising edge SHALL force: state IDLE, count 0, pointers 0, misalign_err 0, mem_req 0, mem_addr 0, instr_valid 0, instr_out 0, instr_pc 0.
REQ-036 Reset SHALL take priority over flush, mem_ack, and all transfers, including mid-request; a later mem_ack for the aborted request is ignored by REQ-023.
REQ-037 pc_ready SHALL be 0 while reset=0 and 1 in the first cycle after release (IDLE, empty).

Verification
REQ-038 Basic fetch: pc_addr=0x00000040 accepted, mem_ack after 3 cycles with 0x2008000A -> instr_valid=1, instr_out=0x2008000A, instr_pc=0x40 one cycle after ack.
REQ-039 Backpressure: instr_ready=0, fetch 0x0 and 0x4 -> count=2, pc_ready=0; pop once -> pc_ready=1 next cycle, head instr_pc=0x4.
REQ-040 Flush mid-request: accept 0x100, flush before ack, ack 2 cycles later with 0xDEADBEEF -> instr_valid never 1, pc_ready=1 cycle after ack.
REQ-041 Flush coincident with ack: data 0x12345678 dropped, queue empty, IDLE next cycle.
REQ-042 Misaligned: pc_addr=0x00000042 -> no mem_req, misalign_err=1, pc_ready=0; flush -> misalign_err=0.
REQ-043 Reset mid-request: reset=0 while mem_req=1 -> all outputs zero next cycle; late mem_ack produces no queue entry.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-outstanding instruction fetch unit with a 2-entry queue.
//            Flush discards queued and in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_addr,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        misalign_err
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_REQ   = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   logic [1:0]  r_state;
   logic        r_mem_req;
   logic [31:0] r_mem_addr;
   logic        r_misalign;
   logic [1:0]  r_count;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [31:0] r_q_pc    [2];
   logic [31:0] r_q_instr [2];

   logic w_xfer;
   logic w_aligned;
   logic w_push;
   logic w_pop;
   logic w_not_empty;

   assign w_not_empty = (r_count != 2'd0);
   assign w_aligned   = (pc_addr[1:0] == 2'b00);

   // Ready is forced low during reset so nothing is accepted mid-reset.
   assign pc_ready = reset & (r_state == c_IDLE) & (r_count < 2'd2)
                     & ~flush & ~r_misalign;
   assign w_xfer   = pc_valid & pc_ready;
   assign w_push   = (r_state == c_REQ) & mem_ack & ~flush;
   assign w_pop    = w_not_empty & instr_ready & ~flush;

   assign mem_req      = r_mem_req;
   assign mem_addr     = r_mem_addr;
   assign misalign_err = r_misalign;
   assign instr_valid  = w_not_empty;
   assign instr_out    = w_not_empty ? r_q_instr[r_rd_ptr] : 32'd0;
   assign instr_pc     = w_not_empty ? r_q_pc[r_rd_ptr]    : 32'd0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= c_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_xfer && w_aligned) begin
                  r_state    <= c_REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= pc_addr;
               end
            end
            c_REQ: begin
               if (mem_ack) begin
                  r_state   <= c_IDLE;
                  r_mem_req <= 1'b0;
               end else if (flush) begin
                  r_state <= c_DRAIN;
               end
            end
            c_DRAIN: begin
               // Request stays on the bus until the discarded response returns.
               if (mem_ack) begin
                  r_state   <= c_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= c_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_misalign <= 1'b0;
      end else if (flush) begin
         r_misalign <= 1'b0;
      end else if (w_xfer && !w_aligned) begin
         r_misalign <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count      <= 2'd0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_q_pc[0]    <= 32'd0;
         r_q_pc[1]    <= 32'd0;
         r_q_instr[0] <= 32'd0;
         r_q_instr[1] <= 32'd0;
      end else if (flush) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_mem_addr;
            r_q_instr[r_wr_ptr] <= mem_rdata;
            r_wr_ptr            <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire
